// File: rtl/seq_counter_pkg.sv
// Shared definitions for the programmable-sequence counter.
//   DIR_FWD / DIR_BWD : encodings of the dir input
//   default_code()    : reset value of table entry i (i mod 2^width)
package seq_counter_pkg;

  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_BWD = 1'b1;

  // Identity code for table slot i, folded into the code width.
  function automatic int unsigned default_code(input int unsigned i,
                                               input int unsigned width);
    if (width >= 32) return i;
    return i % (32'd1 << width);
  endfunction

endpackage

// File: rtl/seq_table.sv
// Sequence code register file: DEPTH entries of WIDTH bits.
// Synchronous reset loads the identity sequence (entry i = i mod 2^WIDTH).
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   we/waddr/wdata : single write port (caller guarantees waddr < DEPTH)
//   raddr/rdata    : combinational read port
module seq_table
  import seq_counter_pkg::*;
#(
  parameter  int unsigned WIDTH = 3,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IDXW-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IDXW-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Storage: reset-to-identity, otherwise one write per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= WIDTH'(default_code(i, WIDTH));
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/seq_counter.sv
// Programmable-sequence counter: walks a run-time loaded table of codes
// forward or backward, wrapping at a programmable length.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   en, dir, restart    : step enable, direction (0 fwd / 1 bwd), force idx to 0
//   cfg_we/addr/data    : table write
//   len_we/len_data     : sequence length write (legal 1..DEPTH)
//   count               : table[idx]
//   idx                 : current position
//   wrap                : pulse in the cycle showing a wrapped position
//   cfg_err             : pulse after a rejected length or table write
module seq_counter
  import seq_counter_pkg::*;
#(
  parameter  int unsigned WIDTH = 3,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             restart,
  input  logic             cfg_we,
  input  logic [IDXW-1:0]  cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             len_we,
  input  logic [IDXW:0]    len_data,
  output logic [WIDTH-1:0] count,
  output logic [IDXW-1:0]  idx,
  output logic             wrap,
  output logic             cfg_err
);

  localparam int unsigned LENW = IDXW + 1;
  localparam logic [LENW-1:0] LEN_MAX = LENW'(DEPTH);

  logic [LENW-1:0] len_q,  len_nxt;
  logic [IDXW-1:0] idx_q,  idx_nxt;
  logic            wrap_q, wrap_nxt;
  logic            err_q,  err_nxt;

  logic            len_ok;
  logic            addr_ok;
  logic            tbl_we;
  logic [LENW-1:0] last;

  // Request qualification; addr is widened so the range check stays meaningful
  // for power-of-two DEPTH as well.
  always_comb begin
    len_ok  = (len_data != '0) && (len_data <= LEN_MAX);
    addr_ok = ({1'b0, cfg_addr} < LEN_MAX);
    tbl_we  = cfg_we && addr_ok;
    last    = len_q - LENW'(1);
  end

  // Next-state: accepted length write > restart > step.
  always_comb begin
    len_nxt  = len_q;
    idx_nxt  = idx_q;
    wrap_nxt = 1'b0;
    err_nxt  = (len_we && !len_ok) || (cfg_we && !addr_ok);

    if (len_we && len_ok) begin
      len_nxt = len_data;
      idx_nxt = '0;
    end else if (restart) begin
      idx_nxt = '0;
    end else if (en) begin
      if (dir == DIR_FWD) begin
        if ({1'b0, idx_q} == last) begin
          idx_nxt  = '0;
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx_q + IDXW'(1);
        end
      end else begin
        if (idx_q == '0) begin
          idx_nxt  = IDXW'(last);
          wrap_nxt = 1'b1;
        end else begin
          idx_nxt = idx_q - IDXW'(1);
        end
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q  <= LEN_MAX;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      len_q  <= len_nxt;
      idx_q  <= idx_nxt;
      wrap_q <= wrap_nxt;
      err_q  <= err_nxt;
    end
  end

  seq_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_table (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_q),
    .rdata (count)
  );

  assign idx     = idx_q;
  assign wrap    = wrap_q;
  assign cfg_err = err_q;

endmodule

// File: tb/tb_seq_counter.sv
// Bench for seq_counter: directed walk of the documented scenarios plus a
// randomized phase, all checked against a behavioural table/length model.
module tb_seq_counter;

  localparam int unsigned WIDTH = 3;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDXW  = $clog2(DEPTH);
  localparam int unsigned NCODE = 1 << WIDTH;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             en = 1'b0;
  logic             dir = 1'b0;
  logic             restart = 1'b0;
  logic             cfg_we = 1'b0;
  logic [IDXW-1:0]  cfg_addr = '0;
  logic [WIDTH-1:0] cfg_data = '0;
  logic             len_we = 1'b0;
  logic [IDXW:0]    len_data = '0;
  logic [WIDTH-1:0] count;
  logic [IDXW-1:0]  idx;
  logic             wrap;
  logic             cfg_err;

  seq_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .dir      (dir),
    .restart  (restart),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .len_we   (len_we),
    .len_data (len_data),
    .count    (count),
    .idx      (idx),
    .wrap     (wrap),
    .cfg_err  (cfg_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int unsigned m_tbl [DEPTH];
  int unsigned m_len;
  int unsigned m_idx;
  bit          m_wrap;
  bit          m_err;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model of one clock edge with the given inputs.
  task automatic model_edge(input bit r, e, d, rs, cw, input int unsigned ca, cd,
                            input bit lw, input int unsigned ld);
    m_wrap = 0;
    m_err  = 0;
    if (r) begin
      for (int i = 0; i < DEPTH; i++) m_tbl[i] = i % NCODE;
      m_len = DEPTH;
      m_idx = 0;
    end else begin
      if (cw) begin
        if (ca < DEPTH) m_tbl[ca] = cd % NCODE;
        else m_err = 1;
      end
      if (lw && ld >= 1 && ld <= DEPTH) begin
        m_len = ld;
        m_idx = 0;
      end else begin
        if (lw) m_err = 1;
        if (rs) m_idx = 0;
        else if (e) begin
          if (!d) begin
            m_wrap = (m_idx == m_len - 1);
            m_idx  = (m_idx + 1) % m_len;
          end else begin
            m_wrap = (m_idx == 0);
            m_idx  = (m_idx + m_len - 1) % m_len;
          end
        end
      end
    end
  endtask

  // Drive one cycle, then compare all outputs against the model.
  task automatic step(input bit r, e, d, rs, cw, input int unsigned ca, cd,
                      input bit lw, input int unsigned ld);
    reset    = r;
    en       = e;
    dir      = d;
    restart  = rs;
    cfg_we   = cw;
    cfg_addr = IDXW'(ca);
    cfg_data = WIDTH'(cd);
    len_we   = lw;
    len_data = (IDXW+1)'(ld);
    @(posedge clk);
    model_edge(r, e, d, rs, cw, ca, cd, lw, ld);
    #1;
    check("count",   32'(count),   m_tbl[m_idx]);
    check("idx",     32'(idx),     m_idx);
    check("wrap",    32'(wrap),    32'(m_wrap));
    check("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic en_step(input bit d);
    step(0, 1, d, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  int unsigned exp_seq [];
  int unsigned wr_tbl  [6];

  initial begin
    // Reset then default identity walk.
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_count", 32'(count), 0);
    check("rst_idx",   32'(idx),   0);
    exp_seq = '{1, 2, 3, 4, 5, 6, 7, 0};
    foreach (exp_seq[i]) begin
      en_step(0);
      check("dflt_seq", 32'(count), exp_seq[i]);
      check("dflt_wrap", 32'(wrap), (i == 7) ? 1 : 0);
    end

    // Program 6-entry table and length 6.
    wr_tbl = '{0, 3, 1, 7, 6, 4};
    foreach (wr_tbl[i]) step(0, 0, 0, 0, 1, i, wr_tbl[i], 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 6);
    check("len6_count", 32'(count), 0);
    exp_seq = '{3, 1, 7, 6, 4, 0, 3};
    foreach (exp_seq[i]) begin
      en_step(0);
      check("prog_seq", 32'(count), exp_seq[i]);
      check("prog_wrap", 32'(wrap), (i == 5) ? 1 : 0);
    end

    // Backward from idx 0, then reverse.
    step(0, 0, 0, 1, 0, 0, 0, 0, 0);
    check("restart_idx", 32'(idx), 0);
    exp_seq = '{4, 6, 7, 1};
    foreach (exp_seq[i]) begin
      en_step(1);
      check("bwd_seq", 32'(count), exp_seq[i]);
      check("bwd_wrap", 32'(wrap), (i == 0) ? 1 : 0);
      if (i == 0) check("bwd_idx", 32'(idx), 5);
    end
    en_step(0);
    check("rev_seq", 32'(count), 7);
    en_step(0);
    check("rev_seq", 32'(count), 6);
    check("rev_idx", 32'(idx), 4);

    // Illegal lengths: error pulse, en still steps, length stays 6.
    step(0, 1, 0, 0, 0, 0, 0, 1, 0);
    check("len0_err", 32'(cfg_err), 1);
    check("len0_idx", 32'(idx), 5);
    step(0, 1, 0, 0, 0, 0, 0, 1, 9);
    check("len9_err", 32'(cfg_err), 1);
    check("len9_idx", 32'(idx), 0);
    check("len9_wrap", 32'(wrap), 1);
    idle();
    check("err_clr", 32'(cfg_err), 0);
    repeat (4) en_step(0);
    check("at4_idx", 32'(idx), 4);
    step(0, 1, 0, 0, 0, 0, 0, 1, 3);
    check("len3_idx", 32'(idx), 0);
    check("len3_err", 32'(cfg_err), 0);
    exp_seq = '{3, 1, 0};
    foreach (exp_seq[i]) begin
      en_step(0);
      check("len3_seq", 32'(count), exp_seq[i]);
    end
    check("len3_wrap", 32'(wrap), 1);

    // Write to the next position while stepping into it.
    step(0, 0, 0, 0, 0, 0, 0, 1, 6);
    en_step(0);
    en_step(0);
    check("at2_idx", 32'(idx), 2);
    step(0, 1, 0, 0, 1, 3, 5, 0, 0);
    check("wr_next", 32'(count), 5);
    step(0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("restart_en", 32'(idx), 0);

    // Reset mid-sequence with en high.
    en_step(0);
    en_step(0);
    step(1, 1, 0, 0, 0, 0, 0, 0, 0);
    check("rst2_count", 32'(count), 0);
    check("rst2_idx", 32'(idx), 0);
    en_step(0);
    check("rst2_next", 32'(count), 1);
    repeat (3) en_step(0);
    check("rst2_tbl", 32'(count), 4);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 3) != 0),
           1'($urandom),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) == 0),
           $urandom_range(0, DEPTH - 1),
           $urandom_range(0, NCODE - 1),
           ($urandom_range(0, 9) == 0),
           $urandom_range(0, 15));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_counter.md
# seq_counter

Parametrised, programmable-sequence counter. It steps through a run-time-loaded table of up to DEPTH arbitrary WIDTH-bit codes, forward or backward, wrapping at a programmable length. It is the general replacement for the team's fixed-sequence 3-bit counters, such as Gray-like and arbitrary cycle generators. It sits between the config bus (table and length writes) and any datapath that needs a non-binary count.

## Interface
- WIDTH, 3: bit width of each sequence code and of `count`
- DEPTH, 8: table entries (maximum sequence length), ≥2
- IDXW, $clog2(DEPTH): index width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  one clock; reset is synchronous and active-high
- en  in  1  advance one step this cycle
- dir  in  1  0 = forward (idx+1), 1 = backward (idx−1)
- restart  in  1  force idx to 0
- cfg_we  in  1  write table[cfg_addr] ← cfg_data
- cfg_addr  in  IDXW  table write address
- cfg_data  in  WIDTH  table write data
- len_we  in  1  write sequence length
- len_data  in  IDXW+1  new length; legal range 1..DEPTH
- count  out  WIDTH  table[idx]
- idx  out  IDXW  current sequence position
- wrap  out  1  one-cycle pulse after a wrapping step
- cfg_err  out  1  one-cycle pulse after a rejected len_we

## Operation
- State: table[0..DEPTH−1], len, idx, wrap, cfg_err. All are registers.
- `count` = table[idx], read combinationally from registers only. There is no path from inputs to outputs.
- Reset values:
  - idx=0
  - len=DEPTH
  - table[i]=i mod 2^WIDTH
  - wrap=0, cfg_err=0
  - hence count=0
- idx update priority, highest first:
  1. reset
  2. accepted len_we: idx←0, en ignored
  3. restart: idx←0
  4. en
- Forward step: idx = len−1 → 0 with wrap←1; otherwise idx+1.
- Backward step: idx = 0 → len−1 with wrap←1; otherwise idx−1.
- wrap is 0 on every cycle without a wrapping step.
- len_we handling:
  - len_data in 1..DEPTH: len←len_data, idx←0.
  - len_data = 0 or > DEPTH: len unchanged, idx follows the normal priority as if len_we=0, cfg_err←1 for one cycle.
- len=1: every en step wraps; idx stays 0; wrap pulses on each en.
- cfg_we is independent of idx control and may coincide with en, restart or len_we. Both take effect at the same edge.
- cfg_addr ≥ DEPTH (non-power-of-two DEPTH): write ignored, cfg_err←1.
- The table may hold duplicate codes. No uniqueness check.

## Timing
- Step latency: en sampled at edge N gives new idx/count visible after edge N. wrap is high in the same cycle as the wrapped count.
- Table write at edge N to the current or next idx is visible on `count` after edge N. This includes a simultaneous en step to that address, which shows cfg_data.
- dir is sampled per cycle. Reversing direction mid-sequence costs no extra cycle.
- Reset asserted mid-sequence with en=1: after that edge all state equals the reset values. Table contents are re-initialised, and programmed sequences are lost.
- Sustained throughput: one step per cycle.

## Structure
- Shared package seq_counter_pkg holds DIR_FWD=1'b0 and DIR_BWD=1'b1, and a function computing the default table entry i mod 2^WIDTH.
- One sub-module, seq_table: a DEPTH×WIDTH register file with synchronous reset-to-identity, one write port and one combinational read port.
- Top-level seq_counter holds the len/idx control, wrap and cfg_err.

## Test plan
- Reset then en=1 for 8 cycles (defaults) → count 1,2,…,7,0. wrap=1 only on the cycle count returns to 0. idx tracks count.
- Write 0,3,1,7,6,4 to addr 0..5, len_we with 6, then en=1 → count 0,3,1,7,6,4,0,3. wrap on each return to 0.
- With the same table at idx=0, dir=1 and en=1 → count 4 (idx 5, wrap=1), then 6, 7, 1. Flip dir=0 → 7, 6.
- len_we with 0, then with 9 (DEPTH=8) → cfg_err pulses each time and len stays 6. len_we with 3 while idx=4 → idx=0 next cycle, then sequence 0,3,1,0.
- At idx=2, en=1 with cfg_we addr 3 data 5 → count=5 next cycle. restart and en together → idx=0.
- Reset asserted mid-sequence with en=1 → idx=0, count=0, len=8, table back to identity. Next en → count=1.
